// File: rtl/mips8_pkg.sv
// Shared constants for the 8-bit MIPS datapath: fetch state encodings,
// instruction-register lane enables and the reset vector.
package mips8_pkg;

  typedef enum logic [1:0] {
    FETCH_LO = 2'd0,
    FETCH_HI = 2'd1,
    HOLD     = 2'd2
  } fetch_state_e;

  localparam logic [1:0] IR_NONE  = 2'b00;
  localparam logic [1:0] IR_LO    = 2'b01;
  localparam logic [1:0] IR_HI    = 2'b10;

  localparam logic [7:0] RESET_PC = 8'h00;

endpackage : mips8_pkg

// File: rtl/ir_fetch_seq.sv
// Byte-serial instruction fetch: reads the low then high byte of each 16-bit
// instruction, steers them into the IR lanes and offers the result to decode.
module ir_fetch_seq
  import mips8_pkg::*;
#(
  parameter int N  = 8,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd,
  input  logic [N-1:0]  mem_rdata,
  input  logic          mem_ready,
  output logic [1:0]    ir_en,
  output logic [N-1:0]  ir_d,
  output logic          instr_valid,
  output logic [AW-1:0] instr_pc,
  input  logic          instr_ack,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_pc
);

  fetch_state_e  r_state;
  fetch_state_e  w_next_state;
  logic [AW-1:0] r_pc;
  logic [AW-1:0] w_next_pc;
  logic [AW-1:0] w_reset_pc;
  logic [AW-1:0] w_align_mask;
  logic [AW-1:0] w_odd_bit;

  assign w_reset_pc   = AW'(RESET_PC);
  assign w_odd_bit    = AW'(1);
  assign w_align_mask = ~w_odd_bit;

  assign ir_d     = mem_rdata;
  assign instr_pc = r_pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= FETCH_LO;
      r_pc    <= w_reset_pc;
    end else begin
      r_state <= w_next_state;
      r_pc    <= w_next_pc;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_pc    = r_pc;
    mem_rd       = 1'b0;
    mem_addr     = {AW{1'b0}};
    ir_en        = IR_NONE;
    instr_valid  = 1'b0;

    if (rst) begin
      w_next_state = FETCH_LO;
      w_next_pc    = w_reset_pc;
    end else begin
      case (r_state)
        FETCH_LO: begin
          mem_rd   = 1'b1;
          mem_addr = r_pc;
          if (mem_ready) begin
            ir_en        = IR_LO;
            w_next_state = FETCH_HI;
          end else begin
            w_next_state = FETCH_LO;
          end
        end
        FETCH_HI: begin
          mem_rd   = 1'b1;
          mem_addr = r_pc | w_odd_bit;
          if (mem_ready) begin
            ir_en        = IR_HI;
            w_next_state = HOLD;
          end else begin
            w_next_state = FETCH_HI;
          end
        end
        HOLD: begin
          instr_valid = 1'b1;
          if (instr_ack) begin
            w_next_pc    = r_pc + AW'(2);
            w_next_state = FETCH_LO;
          end else begin
            w_next_state = HOLD;
          end
        end
        default: begin
          w_next_state = FETCH_LO;
        end
      endcase

      // A taken branch squashes whatever this cycle would have delivered.
      if (redirect) begin
        ir_en        = IR_NONE;
        instr_valid  = 1'b0;
        w_next_pc    = redirect_pc & w_align_mask;
        w_next_state = FETCH_LO;
      end else begin
        w_next_pc    = w_next_pc & w_align_mask;
      end
    end
  end

endmodule : ir_fetch_seq

// File: tb/tb_ir_fetch_seq.sv
// Self-checking bench for ir_fetch_seq: a byte memory model feeds the DUT and
// expected IR lane writes are queued at drive time and popped when they appear.
module tb_ir_fetch_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] mem_addr;
  logic       mem_rd;
  logic [7:0] mem_rdata;
  logic       mem_ready = 1'b0;
  logic [1:0] ir_en;
  logic [7:0] ir_d;
  logic       instr_valid;
  logic [7:0] instr_pc;
  logic       instr_ack = 1'b0;
  logic       redirect = 1'b0;
  logic [7:0] redirect_pc = 8'h00;

  logic [7:0] mem [256];
  logic [9:0] exp_q [$];
  logic [9:0] e;
  int n_pass = 0;
  int n_total = 0;

  ir_fetch_seq #(.N(8), .AW(8)) dut (
    .clk(clk), .rst(rst),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .ir_en(ir_en), .ir_d(ir_d),
    .instr_valid(instr_valid), .instr_pc(instr_pc), .instr_ack(instr_ack),
    .redirect(redirect), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];

  task automatic win(input logic rs, input logic rdy, input logic ack,
                     input logic rd, input logic [7:0] rp);
    @(negedge clk);
    rst = rs; mem_ready = rdy; instr_ack = ack; redirect = rd; redirect_pc = rp;
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      win(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
      n_total++; if (mem_rd !== 1'b0) $display("FAIL rst_mem_rd got=%b exp=0", mem_rd); else n_pass++;
      n_total++; if (ir_en !== 2'b00) $display("FAIL rst_ir_en got=%b exp=00", ir_en); else n_pass++;
      n_total++; if (instr_valid !== 1'b0) $display("FAIL rst_valid got=%b exp=0", instr_valid); else n_pass++;
      n_total++; if (mem_addr !== 8'h00) $display("FAIL rst_addr got=%h exp=00", mem_addr); else n_pass++;
    end
  endtask

  task automatic test_basic();
    win(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    exp_q.push_back({2'b01, 8'h34});
    n_total++; if (mem_rd !== 1'b1 || mem_addr !== 8'h00) $display("FAIL basic_lo_addr got=%b/%h exp=1/00", mem_rd, mem_addr); else n_pass++;
    e = exp_q.pop_front();
    n_total++; if ({ir_en, ir_d} !== e) $display("FAIL basic_lo_ir got=%b/%h exp=%b/%h", ir_en, ir_d, e[9:8], e[7:0]); else n_pass++;
    win(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    exp_q.push_back({2'b10, 8'h12});
    n_total++; if (mem_addr !== 8'h01) $display("FAIL basic_hi_addr got=%h exp=01", mem_addr); else n_pass++;
    e = exp_q.pop_front();
    n_total++; if ({ir_en, ir_d} !== e) $display("FAIL basic_hi_ir got=%b/%h exp=%b/%h", ir_en, ir_d, e[9:8], e[7:0]); else n_pass++;
    win(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    n_total++; if (instr_valid !== 1'b1 || instr_pc !== 8'h00) $display("FAIL basic_valid got=%b/%h exp=1/00", instr_valid, instr_pc); else n_pass++;
    n_total++; if (mem_rd !== 1'b0 || ir_en !== 2'b00) $display("FAIL basic_hold_bus got=%b/%b exp=0/00", mem_rd, ir_en); else n_pass++;
    win(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    n_total++; if (mem_addr !== 8'h02 || mem_rd !== 1'b1) $display("FAIL basic_next_addr got=%h/%b exp=02/1", mem_addr, mem_rd); else n_pass++;
  endtask

  task automatic test_wait_states();
    for (int i = 0; i < 2; i++) begin
      win(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      n_total++; if (mem_rd !== 1'b1 || mem_addr !== 8'h02 || ir_en !== 2'b00)
        $display("FAIL wait_stable got=%b/%h/%b exp=1/02/00", mem_rd, mem_addr, ir_en); else n_pass++;
    end
    win(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    exp_q.push_back({2'b01, mem[2]});
    e = exp_q.pop_front();
    n_total++; if ({ir_en, ir_d} !== e) $display("FAIL wait_lo_ir got=%b/%h exp=%b/%h", ir_en, ir_d, e[9:8], e[7:0]); else n_pass++;
    win(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    exp_q.push_back({2'b10, mem[3]});
    e = exp_q.pop_front();
    n_total++; if ({ir_en, ir_d} !== e) $display("FAIL wait_hi_ir got=%b/%h exp=%b/%h", ir_en, ir_d, e[9:8], e[7:0]); else n_pass++;
  endtask

  task automatic test_hold();
    // mem_ready stays high in HOLD to show it is ignored without a read.
    for (int i = 0; i < 5; i++) begin
      win(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      n_total++; if (instr_valid !== 1'b1 || mem_rd !== 1'b0 || ir_en !== 2'b00 || instr_pc !== 8'h02)
        $display("FAIL hold_stall got=%b/%b/%b/%h exp=1/0/00/02", instr_valid, mem_rd, ir_en, instr_pc); else n_pass++;
    end
    win(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    n_total++; if (instr_valid !== 1'b1) $display("FAIL hold_ack_valid got=%b exp=1", instr_valid); else n_pass++;
    win(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    n_total++; if (mem_addr !== 8'h04 || mem_rd !== 1'b1) $display("FAIL hold_next_addr got=%h/%b exp=04/1", mem_addr, mem_rd); else n_pass++;
  endtask

  task automatic test_redirect();
    win(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    exp_q.push_back({2'b01, mem[4]});
    e = exp_q.pop_front();
    n_total++; if ({ir_en, ir_d} !== e) $display("FAIL redir_lo_ir got=%b/%h exp=%b/%h", ir_en, ir_d, e[9:8], e[7:0]); else n_pass++;
    win(1'b0, 1'b1, 1'b0, 1'b1, 8'h41);
    n_total++; if (ir_en !== 2'b00 || instr_valid !== 1'b0) $display("FAIL redir_squash got=%b/%b exp=00/0", ir_en, instr_valid); else n_pass++;
    win(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    exp_q.push_back({2'b01, mem[8'h40]});
    n_total++; if (mem_addr !== 8'h40) $display("FAIL redir_addr got=%h exp=40", mem_addr); else n_pass++;
    e = exp_q.pop_front();
    n_total++; if ({ir_en, ir_d} !== e) $display("FAIL redir_relo_ir got=%b/%h exp=%b/%h", ir_en, ir_d, e[9:8], e[7:0]); else n_pass++;
    win(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    exp_q.push_back({2'b10, mem[8'h41]});
    n_total++; if (mem_addr !== 8'h41) $display("FAIL redir_hi_addr got=%h exp=41", mem_addr); else n_pass++;
    e = exp_q.pop_front();
    n_total++; if ({ir_en, ir_d} !== e) $display("FAIL redir_rehi_ir got=%b/%h exp=%b/%h", ir_en, ir_d, e[9:8], e[7:0]); else n_pass++;
    win(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    n_total++; if (instr_valid !== 1'b1 || instr_pc !== 8'h40) $display("FAIL redir_pc got=%b/%h exp=1/40", instr_valid, instr_pc); else n_pass++;
  endtask

  task automatic test_wrap();
    win(1'b0, 1'b1, 1'b0, 1'b1, 8'hFF);
    n_total++; if (ir_en !== 2'b00) $display("FAIL wrap_redir_squash got=%b exp=00", ir_en); else n_pass++;
    win(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    exp_q.push_back({2'b01, mem[8'hFE]});
    n_total++; if (mem_addr !== 8'hFE) $display("FAIL wrap_align got=%h exp=fe", mem_addr); else n_pass++;
    e = exp_q.pop_front();
    n_total++; if ({ir_en, ir_d} !== e) $display("FAIL wrap_lo_ir got=%b/%h exp=%b/%h", ir_en, ir_d, e[9:8], e[7:0]); else n_pass++;
    win(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    exp_q.push_back({2'b10, mem[8'hFF]});
    n_total++; if (mem_addr !== 8'hFF) $display("FAIL wrap_hi_addr got=%h exp=ff", mem_addr); else n_pass++;
    e = exp_q.pop_front();
    n_total++; if ({ir_en, ir_d} !== e) $display("FAIL wrap_hi_ir got=%b/%h exp=%b/%h", ir_en, ir_d, e[9:8], e[7:0]); else n_pass++;
    win(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    n_total++; if (instr_pc !== 8'hFE) $display("FAIL wrap_instr_pc got=%h exp=fe", instr_pc); else n_pass++;
    win(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    exp_q.push_back({2'b01, 8'h34});
    n_total++; if (mem_addr !== 8'h00) $display("FAIL wrap_addr got=%h exp=00", mem_addr); else n_pass++;
    e = exp_q.pop_front();
    n_total++; if ({ir_en, ir_d} !== e) $display("FAIL wrap_lo0_ir got=%b/%h exp=%b/%h", ir_en, ir_d, e[9:8], e[7:0]); else n_pass++;
    win(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    exp_q.push_back({2'b10, 8'h12});
    e = exp_q.pop_front();
    n_total++; if ({ir_en, ir_d} !== e) $display("FAIL wrap_hi0_ir got=%b/%h exp=%b/%h", ir_en, ir_d, e[9:8], e[7:0]); else n_pass++;
    win(1'b0, 1'b0, 1'b1, 1'b1, 8'h10);
    n_total++; if (instr_valid !== 1'b0) $display("FAIL ackredir_valid got=%b exp=0", instr_valid); else n_pass++;
    win(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    n_total++; if (mem_addr !== 8'h10 || mem_rd !== 1'b1) $display("FAIL ackredir_addr got=%h/%b exp=10/1", mem_addr, mem_rd); else n_pass++;
  endtask

  task automatic test_rst_mid();
    win(1'b0, 1'b0, 1'b0, 1'b1, 8'h20);
    win(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    exp_q.push_back({2'b01, mem[8'h20]});
    n_total++; if (mem_addr !== 8'h20) $display("FAIL rstmid_addr got=%h exp=20", mem_addr); else n_pass++;
    e = exp_q.pop_front();
    n_total++; if ({ir_en, ir_d} !== e) $display("FAIL rstmid_lo_ir got=%b/%h exp=%b/%h", ir_en, ir_d, e[9:8], e[7:0]); else n_pass++;
    win(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    n_total++; if (mem_rd !== 1'b0 || ir_en !== 2'b00 || mem_addr !== 8'h00)
      $display("FAIL rstmid_forced got=%b/%b/%h exp=0/00/00", mem_rd, ir_en, mem_addr); else n_pass++;
    win(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    n_total++; if (mem_addr !== 8'h00 || mem_rd !== 1'b1 || instr_valid !== 1'b0)
      $display("FAIL rstmid_restart got=%h/%b/%b exp=00/1/0", mem_addr, mem_rd, instr_valid); else n_pass++;
    n_total++; if (exp_q.size() != 0) $display("FAIL sb_leftover got=%0d exp=0", exp_q.size()); else n_pass++;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hA5;
    mem[0] = 8'h34;
    mem[1] = 8'h12;
    test_reset();
    test_basic();
    test_wait_states();
    test_hold();
    test_redirect();
    test_wrap();
    test_rst_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_ir_fetch_seq
